route_dispatch_8: RTL

ROUTE_DISPATCH_8 -- requirements
Module: route_dispatch_8

---
 rtl/route_pkg.sv | 14 +
 rtl/decoder_3_8.sv | 13 +
 rtl/route_dispatch_8.sv | 104 ++++++++++
 3 files changed

// File: rtl/route_pkg.sv
// Shared types and sizes for the 8-lane route dispatcher.
package route_pkg;

  localparam int LANE_N = 8;
  localparam int DEST_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } pkt_state_t;

  typedef logic [LANE_N-1:0] lane_mask_t;

endpackage

// File: rtl/decoder_3_8.sv
// One-hot decode of a 3-bit lane id into an 8-bit lane mask.
module decoder_3_8
  import route_pkg::*;
(
  input  logic [DEST_W-1:0] sel,
  output lane_mask_t        onehot
);

  for (genvar gi = 0; gi < LANE_N; gi++) begin : g_lane
    assign onehot[gi] = (sel == DEST_W'(gi));
  end

endmodule

// File: rtl/route_dispatch_8.sv
// Packet router: one registered output stage fanned out to 8 lanes on a shared bus.
// Optional broadcast to all lanes is enabled by defining ROUTE_BCAST_EN.
module route_dispatch_8
  import route_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [2:0]        s_dest,
  input  logic              s_last,
  input  logic              s_bcast,
  output logic [7:0]        m_valid,
  input  logic [7:0]        m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              err_dest
);

  pkt_state_t        state_reg, state_next;
  logic              out_valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic              last_reg;
  lane_mask_t        lane_mask_reg;
  lane_mask_t        done_mask_reg, done_mask_next;
  logic [DEST_W-1:0] locked_dest_reg;
  logic              err_reg;

  lane_mask_t        decode_mask;
  lane_mask_t        first_mask;
  lane_mask_t        xfer;
  logic              beat_done;
  logic              accept;
  logic              is_first;

  decoder_3_8 u_decoder (
    .sel    (s_dest),
    .onehot (decode_mask)
  );

  assign m_valid = {LANE_N{out_valid_reg}} & lane_mask_reg & ~done_mask_reg;
  assign xfer    = m_valid & m_ready;

`ifdef ROUTE_BCAST_EN
  // A lane that has already taken the beat stays in done_mask until the whole beat retires.
  assign beat_done      = out_valid_reg & (((done_mask_reg | xfer) & lane_mask_reg) == lane_mask_reg);
  assign first_mask     = s_bcast ? '1 : decode_mask;
  assign done_mask_next = (accept | beat_done) ? '0 : (done_mask_reg | xfer);
`else
  logic unused_bcast;
  assign unused_bcast   = s_bcast;
  assign beat_done      = |xfer;
  assign first_mask     = decode_mask;
  assign done_mask_next = '0;
`endif

  // Held low during reset so upstream cannot push into a clearing register.
  assign s_ready  = rst_n & (~out_valid_reg | beat_done);
  assign accept   = s_valid & s_ready;
  assign is_first = (state_reg == ST_IDLE);

  assign m_data   = data_reg;
  assign m_last   = last_reg;
  assign err_dest = err_reg;

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = s_last ? ST_IDLE : ST_PKT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      out_valid_reg   <= 1'b0;
      data_reg        <= '0;
      last_reg        <= 1'b0;
      lane_mask_reg   <= '0;
      done_mask_reg   <= '0;
      locked_dest_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg     <= state_next;
      done_mask_reg <= done_mask_next;
      err_reg       <= accept & ~is_first & (s_dest != locked_dest_reg);
      if (accept) begin
        out_valid_reg <= 1'b1;
        data_reg      <= s_data;
        last_reg      <= s_last;
        if (is_first) begin
          lane_mask_reg   <= first_mask;
          locked_dest_reg <= s_dest;
        end
      end else if (beat_done) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule
